// File: rtl/spi_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module : spi_ram_pkg
// Brief  : Command codes and TX-hold FSM encoding for the SPI RAM controller.
// Rev    : 1.0  initial release
// ============================================================================
package spi_ram_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_HOLD = 1'b1
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_ram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : spi_ram_ctrl_if
// Brief  : Frame-in / byte-out link between the SPI slave and the RAM controller.
// Rev    : 1.0  initial release
// ============================================================================
interface spi_ram_ctrl_if;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       err;

  modport master (output rx_data, rx_valid, input tx_data, tx_valid, err);
  modport slave  (input rx_data, rx_valid, output tx_data, tx_valid, err);
endinterface
`default_nettype wire

// File: rtl/sp_ram_array.sv
`default_nettype none
// ============================================================================
// Module : sp_ram_array
// Brief  : Synchronous single-port byte RAM, read-old-data on write, no reset.
// Rev    : 1.0  initial release
// ============================================================================
module sp_ram_array #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  wire logic                 clk,
  input  wire logic                 we,
  input  wire logic [ADDR_SIZE-1:0] addr,
  input  wire logic [7:0]           din,
  output logic      [7:0]           dout
);

  logic [7:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= din;
    end
    dout <= mem_q[addr];
  end

endmodule
`default_nettype wire

// File: rtl/spi_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module : spi_ram_ctrl
// Brief  : Decodes SPI frames into address/write/read commands on a byte RAM.
// Rev    : 1.0  initial release
// ============================================================================
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 1
) (
  input wire logic     clk,
  input wire logic     rst,
  spi_ram_ctrl_if.slave bus
);

  cmd_e                 cmd_w;
  logic [7:0]           payload_w;
  logic [ADDR_SIZE-1:0] frame_addr_w;

  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE-1:0] hold_addr_q, hold_addr_d;
  logic                 rd_ok_q, rd_ok_d;
  logic                 from_ram_q, from_ram_d;
  logic                 err_q, err_d;
  tx_state_e            state_q, state_d;

  logic                 ram_we_w;
  logic [ADDR_SIZE-1:0] ram_addr_w;
  logic [7:0]           ram_dout_w;

  assign cmd_w        = cmd_e'(bus.rx_data[9:8]);
  assign payload_w    = bus.rx_data[7:0];
  assign frame_addr_w = payload_w[ADDR_SIZE-1:0];

  function automatic logic in_range(input logic [ADDR_SIZE-1:0] p);
    return 32'(p) < MEM_DEPTH;
  endfunction

  function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
    return (32'(p) == MEM_DEPTH - 1) ? '0 : p + ADDR_SIZE'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= TX_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      hold_addr_q <= '0;
      rd_ok_q     <= 1'b0;
      from_ram_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      hold_addr_q <= hold_addr_d;
      rd_ok_q     <= rd_ok_d;
      from_ram_q  <= from_ram_d;
      err_q       <= err_d;
    end
  end

  // Between frames the RAM keeps re-reading the last read address so the
  // registered dout (and therefore tx_data) stays stable while held.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    hold_addr_d = hold_addr_q;
    rd_ok_d     = rd_ok_q;
    from_ram_d  = from_ram_q;
    err_d       = 1'b0;
    ram_we_w    = 1'b0;
    ram_addr_w  = hold_addr_q;

    if (bus.rx_valid) begin
      state_d    = TX_IDLE;
      from_ram_d = 1'b0;
      case (cmd_w)
        CMD_WR_ADDR: wr_ptr_d = frame_addr_w;
        CMD_WR_DATA: begin
          ram_addr_w = wr_ptr_q;
          ram_we_w   = in_range(wr_ptr_q);
          if (AUTO_INC != 0) wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        CMD_RD_ADDR: begin
          rd_ptr_d = frame_addr_w;
          rd_ok_d  = 1'b1;
        end
        default: begin
          state_d     = TX_HOLD;
          ram_addr_w  = rd_ptr_q;
          hold_addr_d = rd_ptr_q;
          if (rd_ok_q && in_range(rd_ptr_q)) begin
            from_ram_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          if (rd_ok_q && (AUTO_INC != 0)) rd_ptr_d = ptr_inc(rd_ptr_q);
        end
      endcase
    end
  end

  sp_ram_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_w),
    .addr (ram_addr_w),
    .din  (payload_w),
    .dout (ram_dout_w)
  );

  assign bus.tx_data  = from_ram_q ? ram_dout_w : 8'h00;
  assign bus.tx_valid = (state_q == TX_HOLD);
  assign bus.err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_ram_ctrl
// Brief  : Directed scoreboard bench for spi_ram_ctrl (depth 256 and depth 200).
// Rev    : 1.0  initial release
// ============================================================================
module tb_spi_ram_ctrl;
  import spi_ram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_ram_ctrl_if bus_a ();
  spi_ram_ctrl_if bus_b ();

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  spi_ram_ctrl #(.MEM_DEPTH(200), .ADDR_SIZE(8), .AUTO_INC(1)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [7:0] txd(input bit sel);
    return sel ? bus_b.tx_data : bus_a.tx_data;
  endfunction
  function automatic logic [7:0] txv(input bit sel);
    return {7'b0, sel ? bus_b.tx_valid : bus_a.tx_valid};
  endfunction
  function automatic logic [7:0] txe(input bit sel);
    return {7'b0, sel ? bus_b.err : bus_a.err};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // One accepted frame on the selected DUT; outputs checked 1 ns after the edge.
  task automatic frame(input bit sel, input cmd_e c, input logic [7:0] p);
    exp_t e;
    @(negedge clk);
    bus_a.rx_valid = !sel;
    bus_b.rx_valid = sel;
    bus_a.rx_data  = {c, p};
    bus_b.rx_data  = {c, p};
    @(posedge clk);
    #1;
    if (c == CMD_RD_DATA) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_empty observed=empty expected=entry");
      end else begin
        e = sb.pop_front();
        chk("rd_data", txd(sel), e.d);
        chk("rd_valid", txv(sel), 8'h01);
        chk("rd_err", txe(sel), {7'b0, e.e});
      end
    end else begin
      chk("tx_clear", txv(sel), 8'h00);
      chk("no_err", txe(sel), 8'h00);
    end
  endtask

  task automatic rd(input bit sel, input logic [7:0] d, input logic e);
    exp_t x;
    x.d = d;
    x.e = e;
    sb.push_back(x);
    frame(sel, CMD_RD_DATA, 8'hA3);
  endtask

  // Idle cycles carry a WR_DATA pattern with rx_valid low: must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus_a.rx_valid = 1'b0;
      bus_b.rx_valid = 1'b0;
      bus_a.rx_data  = {CMD_WR_DATA, 8'hEE};
      bus_b.rx_data  = {CMD_WR_DATA, 8'hEE};
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_a.rx_valid = 1'b0; bus_a.rx_data = '0;
    bus_b.rx_valid = 1'b0; bus_b.rx_data = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_tx_data", txd(0), 8'h00);
    chk("rst_tx_valid", txv(0), 8'h00);
    chk("rst_err", txe(0), 8'h00);
    chk("rst_b_valid", txv(1), 8'h00);

    // Read before any RD_ADDR is illegal.
    rd(0, 8'h00, 1'b1);
    idle(1);
    chk("err_one_cycle", txe(0), 8'h00);
    chk("illegal_hold_valid", txv(0), 8'h01);

    // Basic write then read back; held until the next frame.
    frame(0, CMD_WR_ADDR, 8'h10);
    frame(0, CMD_WR_DATA, 8'hA5);
    frame(0, CMD_RD_ADDR, 8'h10);
    rd(0, 8'hA5, 1'b0);
    idle(2);
    chk("hold_data", txd(0), 8'hA5);
    chk("hold_valid", txv(0), 8'h01);
    frame(0, CMD_WR_ADDR, 8'h00);

    // Auto-increment burst across the 0xFF -> 0x00 wrap.
    frame(0, CMD_WR_ADDR, 8'hFE);
    frame(0, CMD_WR_DATA, 8'h11);
    frame(0, CMD_WR_DATA, 8'h22);
    frame(0, CMD_WR_DATA, 8'h33);
    frame(0, CMD_RD_ADDR, 8'hFE);
    rd(0, 8'h11, 1'b0);
    rd(0, 8'h22, 1'b0);
    rd(0, 8'h33, 1'b0);

    // Read-after-write to the same address in consecutive frames.
    frame(0, CMD_RD_ADDR, 8'h41);
    frame(0, CMD_WR_ADDR, 8'h41);
    frame(0, CMD_WR_DATA, 8'h9C);
    rd(0, 8'h9C, 1'b0);

    // Asynchronous reset while holding; memory survives reset.
    frame(0, CMD_RD_ADDR, 8'h10);
    rd(0, 8'hA5, 1'b0);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", txv(0), 8'h00);
    chk("async_rst_data", txd(0), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    rd(0, 8'h00, 1'b1);
    frame(0, CMD_RD_ADDR, 8'h10);
    rd(0, 8'hA5, 1'b0);

    // Depth-200 instance: wrap at 199 and out-of-range handling.
    frame(1, CMD_WR_ADDR, 8'hC7);
    frame(1, CMD_WR_DATA, 8'h3C);
    frame(1, CMD_WR_DATA, 8'h5A);
    frame(1, CMD_RD_ADDR, 8'hC7);
    rd(1, 8'h3C, 1'b0);
    rd(1, 8'h5A, 1'b0);
    frame(1, CMD_WR_ADDR, 8'hC8);
    frame(1, CMD_WR_DATA, 8'h66);
    frame(1, CMD_RD_ADDR, 8'hC8);
    rd(1, 8'h00, 1'b1);
    idle(1);
    chk("oor_err_one_cycle", txe(1), 8'h00);
    frame(1, CMD_RD_ADDR, 8'h00);
    rd(1, 8'h5A, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
